// File: rtl/conv_stream_feeder_pkg.sv
// Shared types and helpers for the convolution operand stream feeder.
package conv_feeder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Number of a/b pairs emitted by one full walk of the loop nest.
  function automatic longint unsigned total_pairs(input int unsigned fmh,
                                                  input int unsigned fmw,
                                                  input int unsigned ich,
                                                  input int unsigned och,
                                                  input int unsigned k);
    return longint'(fmh) * longint'(fmw) * longint'(och) * longint'(ich) *
           longint'(k) * longint'(k);
  endfunction

  // Width of a counter that must hold 0..n-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_stream_feeder_fifo.sv
// Per-lane synchronous FIFO without fall-through: a pushed word shows at the
// head one edge later. The head reads as zero while the FIFO is empty.
module stream_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         din_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o,
  output logic                     full_o
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign count_o = count_q;
  assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // Pointer and occupancy next-state; pops on an empty FIFO are ignored.
  always_comb begin
    do_pop   = pop_i && !empty_o;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_i, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer/occupancy registers; a push into a full FIFO is a design error.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      assert (!(push_i && full_o)) else $error("stream_fifo: push while full");
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array, written at the write pointer.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/conv_stream_feeder.sv
// Walks the y/x/och/ich/ky/kx loop nest, reads activations and weights from
// 1-cycle-latency memories and streams them as a/b pairs with zero padding.
module conv_stream_feeder
  import conv_feeder_pkg::*;
#(
  parameter int IO_DATA_WIDTH      = 16,
  parameter int FEATURE_MAP_WIDTH  = 1024,
  parameter int FEATURE_MAP_HEIGHT = 1024,
  parameter int INPUT_NB_CHANNELS  = 64,
  parameter int OUTPUT_NB_CHANNELS = 64,
  parameter int KERNEL_SIZE        = 3,
  parameter int FIFO_DEPTH         = 4,
  localparam int ACT_AW = $clog2(FEATURE_MAP_HEIGHT*FEATURE_MAP_WIDTH*INPUT_NB_CHANNELS),
  localparam int WGT_AW = $clog2(OUTPUT_NB_CHANNELS*INPUT_NB_CHANNELS*KERNEL_SIZE*KERNEL_SIZE)
) (
  input  logic                     clk,
  input  logic                     rst_in,
  input  logic                     start,
  output logic                     running,
  output logic                     done,
  output logic [ACT_AW-1:0]        act_mem_read_addr,
  output logic                     act_mem_read_en,
  input  logic [IO_DATA_WIDTH-1:0] act_mem_qout,
  output logic [WGT_AW-1:0]        wgt_mem_read_addr,
  output logic                     wgt_mem_read_en,
  input  logic [IO_DATA_WIDTH-1:0] wgt_mem_qout,
  output logic [IO_DATA_WIDTH-1:0] a_input,
  output logic                     a_valid,
  input  logic                     a_ready,
  output logic [IO_DATA_WIDTH-1:0] b_input,
  output logic                     b_valid,
  input  logic                     b_ready
);

  localparam int PAD = KERNEL_SIZE / 2;
  localparam int YW  = cnt_width(FEATURE_MAP_HEIGHT);
  localparam int XW  = cnt_width(FEATURE_MAP_WIDTH);
  localparam int OW  = cnt_width(OUTPUT_NB_CHANNELS);
  localparam int IW  = cnt_width(INPUT_NB_CHANNELS);
  localparam int KW  = cnt_width(KERNEL_SIZE);
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;

  state_t state_q;
  logic   running_q, done_q;

  logic [YW-1:0] y_q,   y_d;
  logic [XW-1:0] x_q,   x_d;
  logic [OW-1:0] och_q, och_d;
  logic [IW-1:0] ich_q, ich_d;
  logic [KW-1:0] ky_q,  ky_d;
  logic [KW-1:0] kx_q,  kx_d;

  logic inflight_q, pad_q;

  logic y_max, x_max, och_max, ich_max, ky_max, kx_max, last_pair;
  logic in_bounds, issue;
  int   iy, ix;

  logic [CW-1:0]            a_count, b_count;
  logic                     a_empty, b_empty, a_full, b_full;
  logic [IO_DATA_WIDTH-1:0] a_din;

  assign running = running_q;
  assign done    = done_q;

  // Issue decision and memory request decode from registered state only.
  always_comb begin
    y_max   = (y_q   == YW'(FEATURE_MAP_HEIGHT - 1));
    x_max   = (x_q   == XW'(FEATURE_MAP_WIDTH - 1));
    och_max = (och_q == OW'(OUTPUT_NB_CHANNELS - 1));
    ich_max = (ich_q == IW'(INPUT_NB_CHANNELS - 1));
    ky_max  = (ky_q  == KW'(KERNEL_SIZE - 1));
    kx_max  = (kx_q  == KW'(KERNEL_SIZE - 1));
    last_pair = y_max && x_max && och_max && ich_max && ky_max && kx_max;

    iy = int'(y_q) + int'(ky_q) - PAD;
    ix = int'(x_q) + int'(kx_q) - PAD;
    in_bounds = (iy >= 0) && (iy < FEATURE_MAP_HEIGHT) &&
                (ix >= 0) && (ix < FEATURE_MAP_WIDTH);

    issue = (state_q == RUN) &&
            ((int'(a_count) + int'(inflight_q)) < FIFO_DEPTH) &&
            ((int'(b_count) + int'(inflight_q)) < FIFO_DEPTH);

    act_mem_read_en   = issue && in_bounds;
    act_mem_read_addr = '0;
    if (act_mem_read_en)
      act_mem_read_addr = ACT_AW'((iy*FEATURE_MAP_WIDTH + ix)*INPUT_NB_CHANNELS + int'(ich_q));

    wgt_mem_read_en   = issue;
    wgt_mem_read_addr = '0;
    if (issue)
      wgt_mem_read_addr = WGT_AW'(((int'(och_q)*INPUT_NB_CHANNELS + int'(ich_q))*KERNEL_SIZE
                                   + int'(ky_q))*KERNEL_SIZE + int'(kx_q));
  end

  // Loop-nest counters advance on issue; the innermost wrap ripples outward.
  always_comb begin
    y_d = y_q; x_d = x_q; och_d = och_q; ich_d = ich_q; ky_d = ky_q; kx_d = kx_q;
    if (issue) begin
      if (!kx_max) kx_d = kx_q + 1'b1;
      else begin
        kx_d = '0;
        if (!ky_max) ky_d = ky_q + 1'b1;
        else begin
          ky_d = '0;
          if (!ich_max) ich_d = ich_q + 1'b1;
          else begin
            ich_d = '0;
            if (!och_max) och_d = och_q + 1'b1;
            else begin
              och_d = '0;
              if (!x_max) x_d = x_q + 1'b1;
              else begin
                x_d = '0;
                y_d = y_max ? '0 : y_q + 1'b1;
              end
            end
          end
        end
      end
    end
  end

  // Counter registers and the single in-flight slot (pad flag rides along).
  always_ff @(posedge clk) begin
    if (rst_in) begin
      y_q <= '0; x_q <= '0; och_q <= '0; ich_q <= '0; ky_q <= '0; kx_q <= '0;
      inflight_q <= 1'b0;
      pad_q      <= 1'b0;
    end else begin
      y_q <= y_d; x_q <= x_d; och_q <= och_d; ich_q <= ich_d; ky_q <= ky_d; kx_q <= kx_d;
      inflight_q <= issue;
      pad_q      <= issue && !in_bounds;
    end
  end

  // Control FSM with registered running/done outputs.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      state_q   <= IDLE;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          state_q   <= RUN;
          running_q <= 1'b1;
        end
        RUN: if (issue && last_pair) state_q <= DRAIN;
        DRAIN: if (a_empty && b_empty && !inflight_q) begin
          state_q   <= DONE;
          running_q <= 1'b0;
          done_q    <= 1'b1;
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign a_din   = pad_q ? '0 : act_mem_qout;
  assign a_valid = !a_empty;
  assign b_valid = !b_empty;

  stream_fifo #(.WIDTH(IO_DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo_a (
    .clk_i   (clk),
    .rst_i   (rst_in),
    .push_i  (inflight_q),
    .pop_i   (a_valid && a_ready),
    .din_i   (a_din),
    .dout_o  (a_input),
    .count_o (a_count),
    .empty_o (a_empty),
    .full_o  (a_full)
  );

  stream_fifo #(.WIDTH(IO_DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo_b (
    .clk_i   (clk),
    .rst_i   (rst_in),
    .push_i  (inflight_q),
    .pop_i   (b_valid && b_ready),
    .din_i   (wgt_mem_qout),
    .dout_o  (b_input),
    .count_o (b_count),
    .empty_o (b_empty),
    .full_o  (b_full)
  );

  logic unused_full;
  assign unused_full = a_full ^ b_full;

endmodule

// File: tb/tb_conv_stream_feeder.sv
// Self-checking bench for conv_stream_feeder on a 4x4x2x2 K=3 configuration.
module tb_conv_stream_feeder;

  localparam int DW = 16, FMW = 4, FMH = 4, ICH = 2, OCH = 2, K = 3, DEPTH = 4;
  localparam int AAW = $clog2(FMH*FMW*ICH);
  localparam int WAW = $clog2(OCH*ICH*K*K);
  localparam int NPAIRS = 576;

  logic           clk = 1'b0;
  logic           rst_in, start, running, done;
  logic [AAW-1:0] act_mem_read_addr;
  logic           act_mem_read_en;
  logic [DW-1:0]  act_mem_qout;
  logic [WAW-1:0] wgt_mem_read_addr;
  logic           wgt_mem_read_en;
  logic [DW-1:0]  wgt_mem_qout;
  logic [DW-1:0]  a_input, b_input;
  logic           a_valid, a_ready, b_valid, b_ready;

  always #5 clk = ~clk;

  conv_stream_feeder #(
    .IO_DATA_WIDTH(DW), .FEATURE_MAP_WIDTH(FMW), .FEATURE_MAP_HEIGHT(FMH),
    .INPUT_NB_CHANNELS(ICH), .OUTPUT_NB_CHANNELS(OCH), .KERNEL_SIZE(K),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_in(rst_in), .start(start), .running(running), .done(done),
    .act_mem_read_addr(act_mem_read_addr), .act_mem_read_en(act_mem_read_en),
    .act_mem_qout(act_mem_qout),
    .wgt_mem_read_addr(wgt_mem_read_addr), .wgt_mem_read_en(wgt_mem_read_en),
    .wgt_mem_qout(wgt_mem_qout),
    .a_input(a_input), .a_valid(a_valid), .a_ready(a_ready),
    .b_input(b_input), .b_valid(b_valid), .b_ready(b_ready)
  );

  // Source memories: 1-cycle read latency, junk on the bus when not read.
  logic [DW-1:0] act_mem [FMH*FMW*ICH];
  logic [DW-1:0] wgt_mem [OCH*ICH*K*K];
  always @(posedge clk) begin
    act_mem_qout <= act_mem_read_en ? act_mem[act_mem_read_addr] : DW'($urandom);
    wgt_mem_qout <= wgt_mem_read_en ? wgt_mem[wgt_mem_read_addr] : DW'($urandom);
  end

  int checks = 0, errors = 0;
  int expA[$], expB[$];
  int gotA[$], gotB[$];
  int ia, ib, dcnt, ecnt = 0, t0, done_rel, fv_rel;
  logic pa_hold, pb_hold;
  logic [DW-1:0] pa_d, pb_d;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic new_run();
    ia = 0; ib = 0; dcnt = 0; done_rel = -1; fv_rel = -1;
    gotA.delete(); gotB.delete();
    pa_hold = 1'b0; pb_hold = 1'b0;
  endtask

  // One clock: drive inputs at negedge, check transfers/stability, then posedge.
  task automatic step(input logic ra, input logic rb, input logic st);
    @(negedge clk);
    a_ready = ra; b_ready = rb; start = st;
    if (pa_hold) begin chk("a_hold_valid", a_valid, 1); chk("a_hold_data", a_input, pa_d); end
    if (pb_hold) begin chk("b_hold_valid", b_valid, 1); chk("b_hold_data", b_input, pb_d); end
    if (a_valid && fv_rel < 0) fv_rel = ecnt - t0;
    if (a_valid && a_ready) begin
      if (ia < expA.size()) chk("a_data", a_input, expA[ia]);
      else chk("a_extra_transfer", ia, expA.size() - 1);
      gotA.push_back(int'(a_input)); ia++;
    end
    if (b_valid && b_ready) begin
      if (ib < expB.size()) chk("b_data", b_input, expB[ib]);
      else chk("b_extra_transfer", ib, expB.size() - 1);
      gotB.push_back(int'(b_input)); ib++;
    end
    pa_hold = a_valid && !a_ready; pa_d = a_input;
    pb_hold = b_valid && !b_ready; pb_d = b_input;
    if (done) begin dcnt++; done_rel = ecnt - t0; end
    @(posedge clk);
    ecnt++;
  endtask

  task automatic start_run(input logic ra, input logic rb);
    new_run();
    step(ra, rb, 1'b1);
    t0 = ecnt;
  endtask

  // mode 0: both readies high; mode 1: independent random readies.
  task automatic run_to_done(input int mode, input int budget, input int start_at);
    int n = 0;
    logic ra, rb;
    while (dcnt == 0 && n < budget) begin
      ra = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      rb = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      step(ra, rb, (n == start_at));
      n++;
    end
    if (dcnt == 0) chk("done_timeout", dcnt, 1);
    repeat (3) step(1'b1, 1'b1, 1'b0);
    chk("a_transfers", ia, NPAIRS);
    chk("b_transfers", ib, NPAIRS);
    chk("done_pulses", dcnt, 1);
    chk("running_after_done", running, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_in = 1'b1; start = 1'b0;
    @(posedge clk); @(posedge clk);
    #1;
    chk("rst_running", running, 0);
    chk("rst_done", done, 0);
    chk("rst_act_en", act_mem_read_en, 0);
    chk("rst_act_addr", act_mem_read_addr, 0);
    chk("rst_wgt_en", wgt_mem_read_en, 0);
    chk("rst_wgt_addr", wgt_mem_read_addr, 0);
    chk("rst_a_valid", a_valid, 0);
    chk("rst_a_input", a_input, 0);
    chk("rst_b_valid", b_valid, 0);
    chk("rst_b_input", b_input, 0);
    @(negedge clk);
    rst_in = 1'b0;
    pa_hold = 1'b0; pb_hold = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired: observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a_first[9] = '{0, 0, 0, 0, 100, 102, 0, 108, 110};
    int a_last[9]  = '{121, 123, 0, 129, 131, 0, 0, 0, 0};
    int iy, ix;

    for (int i = 0; i < FMH*FMW*ICH; i++) act_mem[i] = DW'(100 + i);
    for (int j = 0; j < OCH*ICH*K*K; j++) wgt_mem[j] = DW'(1000 + j);

    // Golden stream: every output pixel, output channel, input channel, tap.
    for (int y = 0; y < FMH; y++)
      for (int x = 0; x < FMW; x++)
        for (int o = 0; o < OCH; o++)
          for (int c = 0; c < ICH; c++)
            for (int ky = 0; ky < K; ky++)
              for (int kx = 0; kx < K; kx++) begin
                iy = y + ky - K/2;
                ix = x + kx - K/2;
                if (iy >= 0 && iy < FMH && ix >= 0 && ix < FMW)
                  expA.push_back(100 + (iy*FMW + ix)*ICH + c);
                else
                  expA.push_back(0);
                expB.push_back(1000 + ((o*ICH + c)*K + ky)*K + kx);
              end

    rst_in = 1'b1; start = 1'b0; a_ready = 1'b0; b_ready = 1'b0;
    t0 = 0;
    new_run();
    do_reset();

    // Full rate with latency, done timing and border values.
    start_run(1'b1, 1'b1);
    #1;
    chk("run_after_start", running, 1);
    chk("a_valid_edge0", a_valid, 0);
    chk("wgt_en_first_cycle", wgt_mem_read_en, 1);
    chk("wgt_addr_first_cycle", wgt_mem_read_addr, 0);
    chk("act_en_padded_first", act_mem_read_en, 0);
    run_to_done(0, 5000, -1);
    chk("first_valid_edge", fv_rel, 2);
    chk("done_edge", done_rel, 579);
    for (int i = 0; i < 9; i++) begin
      chk("a_first9", gotA[i], a_first[i]);
      chk("b_first9", gotB[i], 1000 + i);
      chk("a_corner9", gotA[NPAIRS-9+i], a_last[i]);
      chk("b_corner9", gotB[NPAIRS-9+i], 1027 + i);
    end

    // Reset in the middle of traffic.
    start_run(1'b1, 1'b1);
    repeat (50) step(1'b1, 1'b1, 1'b0);
    do_reset();

    // Backpressure on lane B only.
    start_run(1'b1, 1'b0);
    repeat (20) step(1'b1, 1'b0, 1'b0);
    #1;
    chk("bp_a_count", ia, 4);
    chk("bp_b_count", ib, 0);
    chk("bp_a_valid", a_valid, 0);
    chk("bp_b_valid", b_valid, 1);
    chk("bp_b_input", b_input, 1000);
    run_to_done(0, 5000, -1);

    // Random per-lane readiness.
    void'($urandom(32'd20240611));
    start_run(1'b0, 1'b0);
    run_to_done(1, 20000, -1);

    // start during RUN is ignored.
    start_run(1'b1, 1'b1);
    run_to_done(0, 5000, 100);

    // Reset at pair 300, then restart from pair 0.
    start_run(1'b1, 1'b1);
    for (int n = 0; n < 2000 && ia < 300; n++) step(1'b1, 1'b1, 1'b0);
    chk("reached_pair300", ia, 300);
    do_reset();
    start_run(1'b1, 1'b1);
    run_to_done(0, 5000, -1);
    chk("restart_a0", gotA[0], 0);
    chk("restart_b0", gotB[0], 1000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
